pipe_stage_skid: RTL

//   Parametrised pipeline-stage register with valid/ready handshake and a 1-entry skid buffer.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_reg_en.sv | 33 +++
 rtl/pipe_stage_skid.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
//  Module  : pipe_pkg
//  Purpose : Shared state encoding and constants for pipeline stage registers.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/pipe_reg_en.sv
// ============================================================================
//  Module  : pipe_reg_en
//  Purpose : Payload register with synchronous reset value and load enable.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_reg_en #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RST_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_skid.sv
// ============================================================================
//  Module  : pipe_stage_skid
//  Purpose : Valid/ready pipeline stage with a one-entry skid buffer and a
//            saturating back-pressure cycle counter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pipe_state_t      state_q, state_d;
    logic             in_ready_q;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             accept;
    logic             send;
    logic             m_en, s_en;
    logic [WIDTH-1:0] m_d, s_d, m_q, s_q;

    assign out_valid = (state_q != ST_EMPTY);
    // Flush wins over a same-cycle offer even when in_ready reads 1.
    assign accept    = in_valid & in_ready_q & ~flush;
    assign send      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        m_en    = 1'b0;
        s_en    = 1'b0;
        m_d     = in_data;
        s_d     = in_data;
        if (flush) begin
            state_d = ST_EMPTY;
            m_en    = 1'b1;
            s_en    = 1'b1;
            m_d     = BUBBLE;
            s_d     = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_BUSY;
                        m_en    = 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && send) begin
                        m_en = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        s_en    = 1'b1;
                    end else if (send) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (send) begin
                        state_d = ST_BUSY;
                        m_en    = 1'b1;
                        m_d     = s_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // in_ready is precomputed from the next state so it leaves a flop directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            stall_q    <= stall_d;
        end
    end

    pipe_reg_en #(
        .WIDTH   (WIDTH),
        .RST_VAL (BUBBLE)
    ) u_main_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (m_en),
        .d_i   (m_d),
        .q_o   (m_q)
    );

    pipe_reg_en #(
        .WIDTH   (WIDTH),
        .RST_VAL (BUBBLE)
    ) u_skid_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (s_en),
        .d_i   (s_d),
        .q_o   (s_q)
    );

    assign in_ready  = in_ready_q;
    assign out_data  = m_q;
    assign stall_cnt = stall_q;

endmodule

`default_nettype wire
